// File: rtl/calc_pkg.sv
// Scan codes, FSM states and key classes shared by the keypad calculator controller.
// Pure declarations: no latency, no flow control.
package calc_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_D0    = 8'h70;
  localparam logic [7:0] SC_D1    = 8'h69;
  localparam logic [7:0] SC_D2    = 8'h72;
  localparam logic [7:0] SC_D3    = 8'h7A;
  localparam logic [7:0] SC_D4    = 8'h6B;
  localparam logic [7:0] SC_D5    = 8'h73;
  localparam logic [7:0] SC_D6    = 8'h74;
  localparam logic [7:0] SC_D7    = 8'h6C;
  localparam logic [7:0] SC_D8    = 8'h75;
  localparam logic [7:0] SC_D9    = 8'h7D;
  localparam logic [7:0] SC_ADD   = 8'h79;
  localparam logic [7:0] SC_SUB   = 8'h7B;
  localparam logic [7:0] SC_MULT  = 8'h7C;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [2:0] {ENT_A, ENT_B, CALC, WAIT, RES} state_t;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_DIGIT, CLS_ADD, CLS_SUB, CLS_MULT, CLS_ENTER, CLS_ESC
  } key_cls_t;

  // Operator vector ordering is {add, sub, mult}.
  function automatic logic [2:0] op_of(input key_cls_t cls);
    case (cls)
      CLS_ADD:  return 3'b100;
      CLS_SUB:  return 3'b010;
      CLS_MULT: return 3'b001;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_code_filter.sv
// Drops break (F0 + following code) and extended-prefix bytes, classifies the rest.
// Combinational classification in the key_valid cycle; no backpressure, strobe in = strobe out.
module ps2_code_filter
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output key_cls_t   key_cls,
  output logic [3:0] key_digit,
  output logic       cls_valid
);

  logic skip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip <= 1'b0;
    end else if (key_valid) begin
      if (key_code == SC_BREAK)
        skip <= 1'b1;
      else if (key_code != SC_EXT)
        skip <= 1'b0;
    end
  end

  always_comb begin
    key_cls   = CLS_NONE;
    key_digit = 4'd0;
    case (key_code)
      SC_D0:    begin key_cls = CLS_DIGIT; key_digit = 4'd0; end
      SC_D1:    begin key_cls = CLS_DIGIT; key_digit = 4'd1; end
      SC_D2:    begin key_cls = CLS_DIGIT; key_digit = 4'd2; end
      SC_D3:    begin key_cls = CLS_DIGIT; key_digit = 4'd3; end
      SC_D4:    begin key_cls = CLS_DIGIT; key_digit = 4'd4; end
      SC_D5:    begin key_cls = CLS_DIGIT; key_digit = 4'd5; end
      SC_D6:    begin key_cls = CLS_DIGIT; key_digit = 4'd6; end
      SC_D7:    begin key_cls = CLS_DIGIT; key_digit = 4'd7; end
      SC_D8:    begin key_cls = CLS_DIGIT; key_digit = 4'd8; end
      SC_D9:    begin key_cls = CLS_DIGIT; key_digit = 4'd9; end
      SC_ADD:   key_cls = CLS_ADD;
      SC_SUB:   key_cls = CLS_SUB;
      SC_MULT:  key_cls = CLS_MULT;
      SC_ENTER: key_cls = CLS_ENTER;
      SC_ESC:   key_cls = CLS_ESC;
      default:  key_cls = CLS_NONE;
    endcase
  end

  // F0 and E0 themselves fall into CLS_NONE, so only the skip flag needs gating here.
  assign cls_valid = key_valid && !skip && (key_cls != CLS_NONE);

endmodule

// File: rtl/calc_key_sequencer.sv
// Keypad calculator controller: builds A/op/B from scan codes, runs one ALU op, holds the result.
// Key effects land one cycle after key_valid; keys arriving while the ALU runs are dropped.
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 2,
  parameter int OPW        = 7,
  parameter int RW         = 14,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  logic [7:0]           key_code,
  output logic [OPW-1:0]       alu_a,
  output logic [OPW-1:0]       alu_b,
  output logic                 op_add,
  output logic                 op_sub,
  output logic                 op_mult,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic signed [RW-1:0] alu_result,
  output logic [RW-1:0]        disp_value,
  output logic                 busy,
  output logic                 err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT);

  key_cls_t   key_cls;
  logic [3:0] key_digit;
  logic       cls_valid;

  ps2_code_filter u_filter (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_cls   (key_cls),
    .key_digit (key_digit),
    .cls_valid (cls_valid)
  );

  state_t         state, state_nx;
  logic [OPW-1:0] a_reg, a_nx, b_reg, b_nx;
  logic [CW-1:0]  a_cnt, a_cnt_nx, b_cnt, b_cnt_nx;
  logic [2:0]     op, op_nx;
  logic [RW-1:0]  disp, disp_nx;
  logic           err_reg, err_nx;
  logic [TW-1:0]  tmo, tmo_nx;
  logic           in_alu, esc;

  function automatic logic [OPW-1:0] append_digit(input logic [OPW-1:0] v, input logic [3:0] d);
    return v * OPW'(10) + OPW'(d);
  endfunction

  assign in_alu = (state == CALC) || (state == WAIT);
  assign esc    = cls_valid && (key_cls == CLS_ESC) && !in_alu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ENT_A;
      a_reg   <= '0;
      b_reg   <= '0;
      a_cnt   <= '0;
      b_cnt   <= '0;
      op      <= '0;
      disp    <= '0;
      err_reg <= 1'b0;
      tmo     <= '0;
    end else begin
      state   <= state_nx;
      a_reg   <= a_nx;
      b_reg   <= b_nx;
      a_cnt   <= a_cnt_nx;
      b_cnt   <= b_cnt_nx;
      op      <= op_nx;
      disp    <= disp_nx;
      err_reg <= err_nx;
      tmo     <= tmo_nx;
    end
  end

  always_comb begin
    state_nx = state;
    a_nx     = a_reg;
    b_nx     = b_reg;
    a_cnt_nx = a_cnt;
    b_cnt_nx = b_cnt;
    op_nx    = op;
    disp_nx  = disp;
    err_nx   = err_reg;
    tmo_nx   = tmo;
    case (state)
      ENT_A: begin
        if (cls_valid) begin
          case (key_cls)
            CLS_DIGIT: begin
              if (a_cnt < CW'(MAX_DIGITS)) begin
                a_nx     = append_digit(a_reg, key_digit);
                a_cnt_nx = a_cnt + 1'b1;
              end
              disp_nx = RW'(a_nx);
            end
            CLS_ADD, CLS_SUB, CLS_MULT: begin
              op_nx    = op_of(key_cls);
              state_nx = ENT_B;
            end
            default: ;
          endcase
        end
      end
      ENT_B: begin
        if (cls_valid) begin
          case (key_cls)
            CLS_DIGIT: begin
              if (b_cnt < CW'(MAX_DIGITS)) begin
                b_nx     = append_digit(b_reg, key_digit);
                b_cnt_nx = b_cnt + 1'b1;
              end
              disp_nx = RW'(b_nx);
            end
            CLS_ADD, CLS_SUB, CLS_MULT: begin
              if (b_cnt == '0)
                op_nx = op_of(key_cls);
            end
            CLS_ENTER: begin
              if (b_cnt != '0)
                state_nx = CALC;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        tmo_nx   = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        // A done arriving on the last timeout cycle still counts as success.
        if (alu_done) begin
          disp_nx  = alu_result;
          state_nx = RES;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          err_nx   = 1'b1;
          disp_nx  = '0;
          state_nx = RES;
        end else begin
          tmo_nx = tmo + 1'b1;
        end
      end
      RES: begin
        if (cls_valid && key_cls == CLS_DIGIT) begin
          a_nx     = OPW'(key_digit);
          a_cnt_nx = CW'(1);
          b_nx     = '0;
          b_cnt_nx = '0;
          op_nx    = '0;
          err_nx   = 1'b0;
          disp_nx  = RW'(key_digit);
          state_nx = ENT_A;
        end
      end
      default: state_nx = ENT_A;
    endcase
    if (esc) begin
      state_nx = ENT_A;
      a_nx     = '0;
      b_nx     = '0;
      a_cnt_nx = '0;
      b_cnt_nx = '0;
      op_nx    = '0;
      disp_nx  = '0;
      err_nx   = 1'b0;
      tmo_nx   = '0;
    end
  end

  assign alu_a      = a_reg;
  assign alu_b      = b_reg;
  assign op_add     = op[2];
  assign op_sub     = op[1];
  assign op_mult    = op[0];
  assign alu_start  = (state == CALC);
  assign busy       = in_alu;
  assign disp_value = disp;
  assign err        = err_reg;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer with a 3-cycle behavioural ALU.
module tb_calc_key_sequencer;

  localparam int OPW = 7;
  localparam int RW  = 14;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 key_valid;
  logic [7:0]           key_code;
  logic [OPW-1:0]       alu_a, alu_b;
  logic                 op_add, op_sub, op_mult;
  logic                 alu_start;
  logic                 alu_done;
  logic signed [RW-1:0] alu_result;
  logic [RW-1:0]        disp_value;
  logic                 busy, err;

  logic                 alu_en = 1'b1;
  logic                 model_done = 1'b0;
  logic [RW-1:0]        model_result = '0;
  logic                 manual_done = 1'b0;
  logic [RW-1:0]        manual_result = '0;
  int                   dly = 0;
  int                   n_start = 0;
  int                   n_total = 0;
  int                   n_pass = 0;
  int                   cyc;

  assign alu_done   = model_done | manual_done;
  assign alu_result = manual_done ? manual_result : model_result;

  always #5 clk = ~clk;

  calc_key_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .op_add     (op_add),
    .op_sub     (op_sub),
    .op_mult    (op_mult),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .disp_value (disp_value),
    .busy       (busy),
    .err        (err)
  );

  // Behavioural ALU: done pulses three cycles after the start pulse.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (dly > 0) begin
      dly = dly - 1;
      if (dly == 0) model_done = 1'b1;
    end
    if (alu_start) begin
      n_start = n_start + 1;
      if (alu_en) begin
        dly = 3;
        if (op_add)       model_result = RW'(alu_a) + RW'(alu_b);
        else if (op_sub)  model_result = RW'(alu_a) - RW'(alu_b);
        else              model_result = RW'(alu_a) * RW'(alu_b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_key(input logic [7:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic wait_idle(input string tag, input int max, output int n);
    n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n = n + 1;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] ops();
    return {29'd0, op_add, op_sub, op_mult};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_disp",  32'(disp_value), 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    check("rst_a",     32'(alu_a), 32'd0);
    check("rst_op",    ops(), 32'd0);
    check("rst_start", {31'd0, alu_start}, 32'd0);

    // 12 + 34
    send_key(8'h69); send_key(8'h72); send_key(8'h79);
    send_key(8'h7A); send_key(8'h6B); send_key(8'h5A);
    check("add_start", {31'd0, alu_start}, 32'd1);
    check("add_busy",  {31'd0, busy}, 32'd1);
    check("add_a",     32'(alu_a), 32'd12);
    check("add_b",     32'(alu_b), 32'd34);
    check("add_op",    ops(), 32'd4);
    wait_idle("add_idle", 20, cyc);
    check("add_disp",  32'(disp_value), 32'd46);
    check("add_nstart", 32'(n_start), 32'd1);

    // From RES a digit restarts: 5 - 9
    send_key(8'h73);
    check("res_digit", 32'(disp_value), 32'd5);
    send_key(8'h7B); send_key(8'h7D); send_key(8'h5A);
    check("sub_a",  32'(alu_a), 32'd5);
    check("sub_b",  32'(alu_b), 32'd9);
    check("sub_op", ops(), 32'd2);
    wait_idle("sub_idle", 20, cyc);
    check("sub_disp", 32'(disp_value), 32'h3FFC);

    // Third digit dropped
    send_key(8'h69); send_key(8'h72); send_key(8'h7A);
    check("max_disp", 32'(disp_value), 32'd12);
    check("max_a",    32'(alu_a), 32'd12);
    send_key(8'h76);
    // Break code swallows the following byte
    send_key(8'h69); send_key(8'hF0); send_key(8'h69);
    check("brk_a", 32'(alu_a), 32'd1);
    send_key(8'h72);
    check("brk_after", 32'(alu_a), 32'd12);
    send_key(8'h76);
    // E0 prefix and Enter in ENT_A change nothing, and E0 does not arm skip
    send_key(8'hE0); send_key(8'h5A);
    check("e0_disp", 32'(disp_value), 32'd0);
    check("e0_busy", {31'd0, busy}, 32'd0);
    send_key(8'h72);
    check("e0_digit", 32'(disp_value), 32'd2);
    send_key(8'h76);

    // Timeout: ALU silent
    alu_en = 1'b0;
    send_key(8'h69); send_key(8'h79); send_key(8'h72); send_key(8'h5A);
    wait_idle("tmo_idle", 200, cyc);
    check("tmo_cycles", 32'(cyc), 32'd65);
    check("tmo_err",  {31'd0, err}, 32'd1);
    check("tmo_disp", 32'(disp_value), 32'd0);
    send_key(8'h69);
    check("tmo_clr_err", {31'd0, err}, 32'd0);
    check("tmo_clr_a",   32'(alu_a), 32'd1);
    check("tmo_clr_b",   32'(alu_b), 32'd0);
    check("tmo_clr_op",  ops(), 32'd0);

    // Reset while waiting; later done must be ignored
    send_key(8'h76);
    send_key(8'h69); send_key(8'h79); send_key(8'h72); send_key(8'h5A);
    repeat (3) @(negedge clk);
    check("rw_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    manual_result = RW'(77);
    manual_done   = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    @(negedge clk);
    check("rw_disp", 32'(disp_value), 32'd0);
    check("rw_busy0", {31'd0, busy}, 32'd0);
    check("rw_a", 32'(alu_a), 32'd0);
    send_key(8'h72);
    check("rw_enta", 32'(disp_value), 32'd2);

    // Operator replacement while B empty; locked after first B digit
    send_key(8'h76);
    alu_en = 1'b1;
    send_key(8'h79);
    check("op_first", ops(), 32'd4);
    send_key(8'h7C);
    check("op_repl", ops(), 32'd1);
    send_key(8'h69);
    check("opb_disp", 32'(disp_value), 32'd1);
    check("opb_b",    32'(alu_b), 32'd1);
    send_key(8'h7B);
    check("op_locked", ops(), 32'd1);
    send_key(8'h76);
    check("esc_op",   ops(), 32'd0);
    check("esc_b",    32'(alu_b), 32'd0);
    check("esc_disp", 32'(disp_value), 32'd0);
    check("esc_nstart", 32'(n_start), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
